// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: prescaler, oversample counter and shadowed divisor.
// Optional fractional divisor enabled by defining FRAC_DIV_EN.
module baud_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int OVS         = 16,
  parameter int DEFAULT_DIV = 651,
  parameter int FRAC_W      = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV_IN,
  input  logic             DIV_LOAD,
  input  logic             RESYNC,
`ifdef FRAC_DIV_EN
  input  logic [FRAC_W-1:0] DIV_FRAC_IN,
`endif
  output logic             OS_TICK,
  output logic             MID_TICK,
  output logic             BIT_TICK,
  output logic             LOAD_PEND,
  output logic             DIV_ERR
);

  localparam int OC_W = $clog2(OVS);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
  localparam logic [OC_W-1:0]  OC_MID  = OC_W'(OVS / 2 - 1);
  localparam logic [OC_W-1:0]  OC_LAST = OC_W'(OVS - 1);

  logic [DIV_W-1:0] pc_q, pc_d, div_q, div_d, shadow_q, shadow_d, target;
  logic [OC_W-1:0]  oc_q, oc_d;
  logic             pend_q, pend_d, os_q, os_d, mid_q, mid_d, bit_q, bit_d, err_q, err_d;
  logic             osEvent, bitEvent, applyShadow;
`ifdef FRAC_DIV_EN
  logic [FRAC_W-1:0] frac_q, frac_d, fracShadow_q, fracShadow_d, acc_q, acc_d;
  logic              extra_q, extra_d;
`endif

  always_comb begin
    pc_d     = pc_q;
    oc_d     = oc_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    os_d     = 1'b0;
    mid_d    = 1'b0;
    bit_d    = 1'b0;
    err_d    = 1'b0;
    target   = div_q - DIV_W'(1);
`ifdef FRAC_DIV_EN
    frac_d       = frac_q;
    fracShadow_d = fracShadow_q;
    acc_d        = acc_q;
    extra_d      = extra_q;
    if (extra_q) target = div_q;
`endif
    // >= rather than == so a divisor shrunk while paused cannot strand pc above it
    osEvent     = EN && (pc_q >= target);
    bitEvent    = osEvent && (oc_q == OC_LAST);
    applyShadow = pend_q && (RESYNC || !EN || bitEvent);

    if (RESYNC) begin
      pc_d = '0;
      oc_d = '0;
`ifdef FRAC_DIV_EN
      acc_d   = '0;
      extra_d = 1'b0;
`endif
    end else if (EN) begin
      if (osEvent) begin
        pc_d  = '0;
        oc_d  = oc_q + OC_W'(1);
        os_d  = 1'b1;
        mid_d = (oc_q == OC_MID);
        bit_d = (oc_q == OC_LAST);
`ifdef FRAC_DIV_EN
        {extra_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_q};
`endif
      end else begin
        pc_d = pc_q + DIV_W'(1);
      end
    end

    if (applyShadow) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
`ifdef FRAC_DIV_EN
      frac_d = fracShadow_q;
`endif
    end

    // A load coinciding with an apply lands in the shadow after the old value moved out
    if (DIV_LOAD) begin
      shadow_d = (DIV_IN < MIN_DIV) ? MIN_DIV : DIV_IN;
      err_d    = (DIV_IN < MIN_DIV);
      pend_d   = 1'b1;
`ifdef FRAC_DIV_EN
      fracShadow_d = DIV_FRAC_IN;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q     <= '0;
      oc_q     <= '0;
      div_q    <= DEF_DIV;
      shadow_q <= DEF_DIV;
      pend_q   <= 1'b0;
      os_q     <= 1'b0;
      mid_q    <= 1'b0;
      bit_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef FRAC_DIV_EN
      frac_q       <= '0;
      fracShadow_q <= '0;
      acc_q        <= '0;
      extra_q      <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      oc_q     <= oc_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      os_q     <= os_d;
      mid_q    <= mid_d;
      bit_q    <= bit_d;
      err_q    <= err_d;
`ifdef FRAC_DIV_EN
      frac_q       <= frac_d;
      fracShadow_q <= fracShadow_d;
      acc_q        <= acc_d;
      extra_q      <= extra_d;
`endif
    end
  end

  assign OS_TICK   = os_q;
  assign MID_TICK  = mid_q;
  assign BIT_TICK  = bit_q;
  assign LOAD_PEND = pend_q;
  assign DIV_ERR   = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed scenarios plus random traffic
// compared against an elapsed-edge-count reference model.
module tb_baud_tick_gen;

  localparam int OVS         = 16;
  localparam int DEFAULT_DIV = 651;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic en = 1'b0;
  logic divLoad = 1'b0;
  logic resync = 1'b0;
  logic [15:0] divIn = '0;
  logic osTick, midTick, bitTick, loadPend, divErr;
`ifdef FRAC_DIV_EN
  logic [3:0] fracIn = '0;
`endif

  baud_tick_gen #(.DIV_W(16), .OVS(OVS), .DEFAULT_DIV(DEFAULT_DIV), .FRAC_W(4)) dut (
    .CLK(clk),
    .RST(rstN),
    .EN(en),
    .DIV_IN(divIn),
    .DIV_LOAD(divLoad),
    .RESYNC(resync),
`ifdef FRAC_DIV_EN
    .DIV_FRAC_IN(fracIn),
`endif
    .OS_TICK(osTick),
    .MID_TICK(midTick),
    .BIT_TICK(bitTick),
    .LOAD_PEND(loadPend),
    .DIV_ERR(divErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  // Reference model: enabled edges since the current bit began, plus divisor bookkeeping
  int n, mDiv, mShadow;
  logic mPend, eOs, eMid, eBit, eErr;
  int cyc, firstOs, firstMid, firstBit, lastOs;

  task automatic modelReset();
    n = 0; mDiv = DEFAULT_DIV; mShadow = DEFAULT_DIV; mPend = 1'b0;
    eOs = 1'b0; eMid = 1'b0; eBit = 1'b0; eErr = 1'b0;
  endtask

  task automatic modelEdge();
    logic applyNow;
    applyNow = 1'b0;
    eOs = 1'b0; eMid = 1'b0; eBit = 1'b0;
    eErr = divLoad && (divIn < 16'd2);
    if (resync) begin
      n = 0;
      applyNow = mPend;
    end else if (en) begin
      n++;
      eOs  = (n % mDiv == 0);
      eMid = (n == (OVS / 2) * mDiv);
      eBit = (n == OVS * mDiv);
      if (eBit) begin
        n = 0;
        applyNow = mPend;
      end
    end else begin
      applyNow = mPend;
    end
    if (applyNow) begin
      mDiv = mShadow;
      mPend = 1'b0;
    end
    if (divLoad) begin
      mShadow = (divIn < 16'd2) ? 2 : int'(divIn);
      mPend = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic ld, input logic [15:0] d, input logic rs);
    en = e; divLoad = ld; divIn = d; resync = rs;
    @(posedge clk);
    modelEdge();
    cyc++;
    @(negedge clk);
    checkOutput("outs", {osTick, midTick, bitTick, loadPend, divErr},
                {eOs, eMid, eBit, mPend, eErr});
    if (osTick && firstOs < 0) firstOs = cyc;
    if (midTick && firstMid < 0) firstMid = cyc;
    if (bitTick && firstBit < 0) firstBit = cyc;
    if (osTick) lastOs = cyc;
  endtask

  task automatic clearMarks();
    cyc = 0; firstOs = -1; firstMid = -1; firstBit = -1;
  endtask

  initial begin
    int startOs;
    logic e, ld, rs;
    modelReset();
    clearMarks();
    lastOs = 0;

    // Power-on reset: everything quiet
    #12;
    checkOutput("reset", {osTick, midTick, bitTick, loadPend, divErr}, 5'b0);
    @(negedge clk);
    rstN = 1'b1;

    // Default divisor, one full bit
    for (int i = 0; i < 10416; i++) applyStimulus(1, 0, 0, 0);
    checkInt("first_os", firstOs, 651);
    checkInt("first_mid", firstMid, 5208);
    checkInt("first_bit", firstBit, 10416);

    // Load 10 mid-bit; held pending until the next bit boundary
    for (int i = 0; i < 100; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 16'd10, 0);
    for (int i = 0; i < 10600; i++) applyStimulus(1, 0, 0, 0);

    // Illegal divisor is clamped to 2 and applied by RESYNC
    applyStimulus(1, 1, 16'd1, 0);
    applyStimulus(1, 0, 0, 1);
    clearMarks();
    for (int i = 0; i < 64; i++) applyStimulus(1, 0, 0, 0);
    checkInt("clamp_os_period", firstOs, 2);

    // Back to 10: load with RESYNC applies the old shadow, second RESYNC applies 10
    applyStimulus(1, 1, 16'd10, 1);
    applyStimulus(1, 0, 0, 1);
    for (int i = 0; i < 200 && n != OVS * mDiv - 1; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    clearMarks();
    for (int i = 0; i < 200; i++) applyStimulus(1, 0, 0, 0);
    checkInt("resync_os", firstOs, 10);
    checkInt("resync_mid", firstMid, 80);

    // EN low for 7 cycles stretches the current os period by exactly 7
    for (int i = 0; i < 20 && (n % mDiv) != 4; i++) applyStimulus(1, 0, 0, 0);
    startOs = lastOs;
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 20 && lastOs == startOs; i++) applyStimulus(1, 0, 0, 0);
    checkInt("pause_stretch", lastOs - startOs, 17);

    // With EN low a pending divisor is applied on the very next edge
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 16'd5, 0);
    applyStimulus(0, 0, 0, 0);
    clearMarks();
    for (int i = 0; i < 200; i++) applyStimulus(1, 0, 0, 0);
    checkInt("en_low_apply", firstOs, 5);

    // Random traffic; EN stays high while a load is pending so applies land on phase boundaries
    for (int i = 0; i < 3000; i++) begin
      e  = mPend ? 1'b1 : (($urandom % 8) != 0);
      ld = e && (($urandom % 40) == 0);
      rs = (($urandom % 60) == 0);
      applyStimulus(e, ld, 16'($urandom_range(0, 12)), rs);
    end

    // Reset mid-operation with a load pending
    applyStimulus(1, 1, 16'd7, 0);
    #2 rstN = 1'b0;
    #1 checkOutput("mid_reset", {osTick, midTick, bitTick, loadPend, divErr}, 5'b0);
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
    clearMarks();
    for (int i = 0; i < 700; i++) applyStimulus(1, 0, 0, 0);
    checkInt("post_reset_os", firstOs, 651);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
